// File: rtl/ldpc_dec_vnode_engine_if.sv
// Bus bundle for the variable-node engine: cnode-message stream in, extrinsic stream out.
// Valid-only streams, no backpressure: the engine takes every cn_val beat, and vn_val marks each extrinsic for exactly one enabled cycle.
interface ldpc_dec_vnode_engine_if #(
    parameter int pLLR_W  = 4,
    parameter int pNODE_W = 5,
    parameter int pW      = 3,
    parameter int pZCNT_W = 8
);
    localparam int TCNT_W = $clog2(pW);

    logic                      cn_val;
    logic                      cn_sop;
    logic                      cn_eop;
    logic [pZCNT_W-1:0]        cn_zcnt;
    logic signed [pLLR_W-1:0]  cn_llr;
    logic                      cn_vmask;
    logic signed [pNODE_W-1:0] cn_msg;

    logic                      vn_val;
    logic                      vn_sop;
    logic                      vn_eop;
    logic signed [pNODE_W-1:0] vn_msg;
    logic [TCNT_W-1:0]         vn_tcnt;
    logic [pZCNT_W-1:0]        vn_zcnt;
    logic                      vn_hd;
    logic                      vn_busy;

    logic                      dbg_flush;
    logic                      dbg_eop_err;

    modport master (
        output cn_val, cn_sop, cn_eop, cn_zcnt, cn_llr, cn_vmask, cn_msg,
        input  vn_val, vn_sop, vn_eop, vn_msg, vn_tcnt, vn_zcnt, vn_hd, vn_busy,
        input  dbg_flush, dbg_eop_err
    );

    modport slave (
        input  cn_val, cn_sop, cn_eop, cn_zcnt, cn_llr, cn_vmask, cn_msg,
        output vn_val, vn_sop, vn_eop, vn_msg, vn_tcnt, vn_zcnt, vn_hd, vn_busy,
        output dbg_flush, dbg_eop_err
    );
endinterface

// File: rtl/ldpc_dec_vnode_engine.sv
// LDPC variable-node engine: accumulates LLR plus pW cnode messages into one bank while the
// other bank is flushed as saturated extrinsics sum - r_ij with the hard decision.
module ldpc_dec_vnode_engine #(
    parameter int pLLR_W  = 4,
    parameter int pNODE_W = 5,
    parameter int pW      = 3,
    parameter int pZCNT_W = 8,
    parameter int pSUM_W  = pNODE_W + $clog2(pW + 1) + 1
) (
    input  logic                   iclk,
    input  logic                   ireset_n,
    input  logic                   iclkena,
    ldpc_dec_vnode_engine_if.slave bus
);
    localparam int                TCNT_W   = $clog2(pW);
    localparam logic [TCNT_W-1:0] LAST     = TCNT_W'(pW - 1);
    localparam logic [TCNT_W-1:0] PRE_LAST = TCNT_W'(pW - 2);

    typedef logic signed [pSUM_W-1:0]  sum_t;
    typedef logic signed [pNODE_W-1:0] node_t;

    localparam sum_t SAT_HI = sum_t'((2 ** (pNODE_W - 1)) - 1);
    localparam sum_t SAT_LO = -SAT_HI;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    node_t              bank [2][pW];

    logic               grp_open;
    logic [TCNT_W-1:0]  tcnt_in;
    sum_t               acc;
    logic [pZCNT_W-1:0] grp_zcnt;
    logic               wr_bank;

    sum_t               flush_sum;
    logic [pZCNT_W-1:0] flush_zcnt;
    logic               flush_bank;
    logic               flush_pend;
    state_t             state;

    node_t              cn_c;
    sum_t               cn_ext;
    sum_t               llr_ext;
    sum_t               acc_nxt;
    logic [TCNT_W-1:0]  wr_idx;
    logic               accept;
    logic               close;
    logic               flush_take;
    logic [TCNT_W-1:0]  rd_idx;
    sum_t               ext_full;
    node_t              ext_sat;

    always_comb begin
        cn_c    = bus.cn_vmask ? node_t'(0) : bus.cn_msg;
        cn_ext  = sum_t'(cn_c);
        llr_ext = sum_t'(bus.cn_llr);
        wr_idx  = bus.cn_sop ? '0 : tcnt_in;
        accept  = bus.cn_val & (bus.cn_sop | grp_open);
        // The group closes purely on count; cn_eop is only cross-checked.
        close   = accept & (wr_idx == LAST);
        acc_nxt = (bus.cn_sop ? llr_ext : acc) + cn_ext;

        flush_take = flush_pend & ((state == IDLE) | (bus.vn_tcnt == LAST));
        rd_idx     = (flush_take || (bus.vn_tcnt == LAST)) ? '0 : bus.vn_tcnt + TCNT_W'(1);
        ext_full   = flush_sum - sum_t'(bank[flush_bank][rd_idx]);

        ext_sat = ext_full[pNODE_W-1:0];
        if (ext_full > SAT_HI) begin
            ext_sat = node_t'(SAT_HI);
        end else if (ext_full < SAT_LO) begin
            ext_sat = node_t'(SAT_LO);
        end
    end

    always_ff @(posedge iclk) begin
        if (iclkena && accept) begin
            bank[wr_bank][wr_idx] <= cn_c;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            grp_open        <= 1'b0;
            tcnt_in         <= '0;
            acc             <= '0;
            grp_zcnt        <= '0;
            wr_bank         <= 1'b0;
            flush_sum       <= '0;
            flush_zcnt      <= '0;
            flush_bank      <= 1'b0;
            flush_pend      <= 1'b0;
            bus.dbg_eop_err <= 1'b0;
        end else if (iclkena) begin
            bus.dbg_eop_err <= accept & (bus.cn_eop != close);
            if (flush_take) begin
                flush_pend <= 1'b0;
            end
            if (accept) begin
                acc <= acc_nxt;
                if (bus.cn_sop) begin
                    grp_zcnt <= bus.cn_zcnt;
                end
                if (close) begin
                    grp_open   <= 1'b0;
                    tcnt_in    <= '0;
                    wr_bank    <= ~wr_bank;
                    flush_sum  <= acc_nxt;
                    flush_zcnt <= bus.cn_sop ? bus.cn_zcnt : grp_zcnt;
                    flush_bank <= wr_bank;
                    flush_pend <= 1'b1;
                end else begin
                    grp_open <= 1'b1;
                    tcnt_in  <= wr_idx + TCNT_W'(1);
                end
            end
        end
    end

    // vn_tcnt doubles as the flush index j.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state       <= IDLE;
            bus.vn_val  <= 1'b0;
            bus.vn_sop  <= 1'b0;
            bus.vn_eop  <= 1'b0;
            bus.vn_msg  <= '0;
            bus.vn_tcnt <= '0;
            bus.vn_zcnt <= '0;
            bus.vn_hd   <= 1'b0;
            bus.vn_busy <= 1'b0;
        end else if (iclkena) begin
            if (flush_take) begin
                state       <= FLUSH;
                bus.vn_val  <= 1'b1;
                bus.vn_sop  <= 1'b1;
                bus.vn_eop  <= (LAST == '0);
                bus.vn_msg  <= ext_sat;
                bus.vn_tcnt <= '0;
                bus.vn_zcnt <= flush_zcnt;
                bus.vn_hd   <= flush_sum[pSUM_W-1];
                bus.vn_busy <= 1'b1;
            end else if ((state == FLUSH) && (bus.vn_tcnt != LAST)) begin
                bus.vn_sop  <= 1'b0;
                bus.vn_eop  <= (bus.vn_tcnt == PRE_LAST);
                bus.vn_msg  <= ext_sat;
                bus.vn_tcnt <= bus.vn_tcnt + TCNT_W'(1);
            end else begin
                state       <= IDLE;
                bus.vn_val  <= 1'b0;
                bus.vn_sop  <= 1'b0;
                bus.vn_eop  <= 1'b0;
                bus.vn_busy <= 1'b0;
            end
        end
    end

    assign bus.dbg_flush = (state == FLUSH);
endmodule

// File: tb/tb_ldpc_dec_vnode_engine.sv
// Directed bench for ldpc_dec_vnode_engine: group-level arithmetic model feeding an expected
// queue, a per-cycle compare process, and literal checks on the logged outputs.
module tb_ldpc_dec_vnode_engine;
    localparam int P_LLR_W  = 4;
    localparam int P_NODE_W = 5;
    localparam int P_W      = 3;
    localparam int P_ZCNT_W = 8;
    localparam int NODE_MAX = 15;

    logic iclk;
    logic ireset_n;
    logic iclkena;

    ldpc_dec_vnode_engine_if #(
        .pLLR_W(P_LLR_W), .pNODE_W(P_NODE_W), .pW(P_W), .pZCNT_W(P_ZCNT_W)
    ) bus ();

    ldpc_dec_vnode_engine #(
        .pLLR_W(P_LLR_W), .pNODE_W(P_NODE_W), .pW(P_W), .pZCNT_W(P_ZCNT_W)
    ) dut (
        .iclk(iclk),
        .ireset_n(ireset_n),
        .iclkena(iclkena),
        .bus(bus)
    );

    typedef struct packed {
        logic signed [4:0] vnode;
        logic [1:0]        tcnt;
        logic [7:0]        zcnt;
        logic              hd;
    } exp_t;

    exp_t exp_q[$];
    int   out_cyc[$];
    int   out_vnode[$];
    int   out_zcnt[$];
    int   out_hd[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_ival_cyc = 0;
    int   t_last;
    logic en_q = 1'b0;

    // clock / reset
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) begin
        cyc  <= cyc + 1;
        en_q <= iclkena;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // model: extrinsic j = clamp(llr + sum(c) - c_j), masked c = 0
    task automatic push_model(input int zcnt, input int llr,
                              input int c0, input int c1, input int c2,
                              input bit m0 = 0, input bit m1 = 0, input bit m2 = 0);
        int   c[3];
        int   sum;
        int   v;
        exp_t e;
        c[0] = m0 ? 0 : c0;
        c[1] = m1 ? 0 : c1;
        c[2] = m2 ? 0 : c2;
        sum = llr + c[0] + c[1] + c[2];
        for (int j = 0; j < P_W; j++) begin
            v = sum - c[j];
            if (v > NODE_MAX) v = NODE_MAX;
            if (v < -NODE_MAX) v = -NODE_MAX;
            e.vnode = 5'(v);
            e.tcnt  = 2'(j);
            e.zcnt  = 8'(zcnt);
            e.hd    = (sum < 0);
            exp_q.push_back(e);
        end
    endtask

    // drivers
    task automatic beat(input bit sop, input bit eop, input int llr, input int zcnt,
                        input bit mask, input int cn);
        @(negedge iclk);
        iclkena      = 1'b1;
        bus.cn_val   = 1'b1;
        bus.cn_sop   = sop;
        bus.cn_eop   = eop;
        bus.cn_llr   = 4'(llr);
        bus.cn_zcnt  = 8'(zcnt);
        bus.cn_vmask = mask;
        bus.cn_msg   = 5'(cn);
        last_ival_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iclk);
            iclkena    = 1'b1;
            bus.cn_val = 1'b0;
            bus.cn_sop = 1'b0;
            bus.cn_eop = 1'b0;
        end
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(negedge iclk);
            iclkena = 1'b0;
        end
    endtask

    task automatic send_group(input int zcnt, input int llr, input int c0, input int c1, input int c2);
        push_model(zcnt, llr, c0, c1, c2);
        beat(1, 0, llr, zcnt, 0, c0);
        beat(0, 0, llr, zcnt, 0, c1);
        beat(0, 1, llr, zcnt, 0, c2);
    endtask

    task automatic clear_logs();
        out_cyc.delete();
        out_vnode.delete();
        out_zcnt.delete();
        out_hd.delete();
    endtask

    task automatic check_vals(input string name, input int v0, input int v1, input int v2);
        check({name, "_count"}, out_vnode.size(), 3);
        if (out_vnode.size() >= 3) begin
            check({name, "_v0"}, out_vnode[0], v0);
            check({name, "_v1"}, out_vnode[1], v1);
            check({name, "_v2"}, out_vnode[2], v2);
        end
    endtask

    // scoreboard: compare every freshly updated output cycle
    always @(negedge iclk) begin
        exp_t e;
        if (ireset_n && en_q) begin
            check("busy_vs_val", int'(bus.vn_busy), int'(bus.vn_val));
            if (bus.vn_val) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got vnode %0d zcnt %0d expected no output",
                             bus.vn_msg, bus.vn_zcnt);
                end else begin
                    e = exp_q.pop_front();
                    check("vnode", int'(bus.vn_msg), int'(e.vnode));
                    check("tcnt", int'(bus.vn_tcnt), int'(e.tcnt));
                    check("zcnt", int'(bus.vn_zcnt), int'(e.zcnt));
                    check("hd", int'(bus.vn_hd), int'(e.hd));
                    check("sop", int'(bus.vn_sop), int'(e.tcnt == 0));
                    check("eop", int'(bus.vn_eop), int'(e.tcnt == 2'(P_W - 1)));
                end
                out_cyc.push_back(cyc);
                out_vnode.push_back(int'(bus.vn_msg));
                out_zcnt.push_back(int'(bus.vn_zcnt));
                out_hd.push_back(int'(bus.vn_hd));
            end
        end
    end

    initial begin
        ireset_n     = 1'b0;
        iclkena      = 1'b1;
        bus.cn_val   = 1'b0;
        bus.cn_sop   = 1'b0;
        bus.cn_eop   = 1'b0;
        bus.cn_zcnt  = '0;
        bus.cn_llr   = '0;
        bus.cn_vmask = 1'b0;
        bus.cn_msg   = '0;

        repeat (2) @(negedge iclk);
        check("rst_val", int'(bus.vn_val), 0);
        check("rst_sop", int'(bus.vn_sop), 0);
        check("rst_eop", int'(bus.vn_eop), 0);
        check("rst_busy", int'(bus.vn_busy), 0);
        check("rst_hd", int'(bus.vn_hd), 0);
        check("rst_vnode", int'(bus.vn_msg), 0);
        check("rst_tcnt", int'(bus.vn_tcnt), 0);
        check("rst_zcnt", int'(bus.vn_zcnt), 0);
        check("rst_state", int'(bus.dbg_flush), 0);
        ireset_n = 1'b1;

        // stray beat with no open group is ignored
        beat(0, 0, 0, 0, 0, 7);
        idle(3);

        // basic extrinsics and latency
        clear_logs();
        send_group(1, 3, 2, -1, 4);
        t_last = last_ival_cyc;
        idle(6);
        check_vals("t1", 6, 9, 4);
        if (out_cyc.size() >= 1) begin
            check("t1_latency", out_cyc[0] - t_last, 2);
            check("t1_hd", out_hd[0], 0);
        end

        // saturation both directions
        clear_logs();
        send_group(2, 7, 15, 15, 15);
        send_group(3, -8, -15, -15, -15);
        idle(8);
        check("t2_count", out_vnode.size(), 6);
        if (out_vnode.size() >= 6) begin
            check("t2_pos_sat", out_vnode[1], 15);
            check("t2_neg_sat", out_vnode[4], -15);
            check("t2_neg_hd", out_hd[5], 1);
        end

        // back-to-back groups, continuous output
        clear_logs();
        send_group(5, 2, 1, 2, 3);
        send_group(6, -3, -4, 5, -6);
        idle(8);
        check("t3_count", out_vnode.size(), 6);
        if (out_vnode.size() >= 6) begin
            check("t3_span", out_cyc[5] - out_cyc[0], 5);
            check("t3_zcnt_a", out_zcnt[2], 5);
            check("t3_zcnt_b", out_zcnt[3], 6);
            check("t3_b_v0", out_vnode[3], -4);
            check("t3_b_v1", out_vnode[4], -13);
        end

        // masked middle position, stray eop mid-group
        clear_logs();
        push_model(7, 1, 3, 9, -2, 0, 1, 0);
        beat(1, 0, 1, 7, 0, 3);
        beat(0, 1, 1, 7, 1, 9);
        beat(0, 1, 1, 7, 0, -2);
        idle(6);
        check_vals("t4", -1, 2, 4);

        // isop restart discards the partial group
        clear_logs();
        beat(1, 0, 0, 8, 0, 5);
        beat(0, 0, 0, 8, 0, 5);
        send_group(9, 0, 1, 1, 1);
        idle(6);
        check_vals("t5_restart", 2, 2, 2);
        if (out_zcnt.size() >= 1) check("t5_restart_zcnt", out_zcnt[0], 9);

        // reset mid-flush
        clear_logs();
        send_group(11, 4, 1, 2, 3);
        for (int i = 0; i < 10 && out_vnode.size() == 0; i++) begin
            @(posedge iclk);
            #1;
        end
        check("t5_first_out", out_vnode.size(), 1);
        check("t5_mid_flush", int'(bus.vn_val), 1);
        ireset_n = 1'b0;
        #1;
        check("t5_rst_val", int'(bus.vn_val), 0);
        check("t5_rst_busy", int'(bus.vn_busy), 0);
        exp_q.delete();
        @(negedge iclk);
        ireset_n = 1'b1;
        clear_logs();
        idle(8);
        check("t5_no_residual", out_vnode.size(), 0);

        // clock-enable stall during input
        clear_logs();
        push_model(12, 3, 2, -1, 4);
        beat(1, 0, 3, 12, 0, 2);
        stall(3);
        beat(0, 0, 3, 12, 0, -1);
        beat(0, 1, 3, 12, 0, 4);
        t_last = last_ival_cyc;
        idle(6);
        check_vals("t6a", 6, 9, 4);
        if (out_cyc.size() >= 1) check("t6a_latency", out_cyc[0] - t_last, 2);

        // clock-enable stall during flush
        clear_logs();
        send_group(13, 3, 2, -1, 4);
        t_last = last_ival_cyc;
        idle(1);
        stall(3);
        idle(8);
        check_vals("t6b", 6, 9, 4);
        if (out_cyc.size() >= 3) begin
            check("t6b_latency", out_cyc[0] - t_last, 2);
            check("t6b_span", out_cyc[2] - out_cyc[0], 5);
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
